pack_i64_ser: RTL and testbench
===============================

PACK_I64_SER -- requirements
Module: pack_i64_ser

Interface
REQ-001 The block SHALL have no parameters; the value width is fixed at 64 bits and the maximum encoded length at 10 bytes.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  64  signed two's-complement value to encode.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  block accepts a value this cycle.
REQ-007 out_byte  output  8  current signed LEB128 byte: bit7 = continuation, bits6:0 = payload.
REQ-008 out_valid  output  1  out_byte valid.
REQ-009 out_ready  input  1  downstream accepts out_byte.
REQ-010 out_last  output  1  out_byte is the final byte of the current value (bit7 = 0).
REQ-011 out_len  output  4  1-based index of out_byte within the current value; equals total length when out_last = 1.

Function
REQ-012 The FSM SHALL have two states: IDLE and EMIT.
REQ-013 IDLE: in_ready = 1, out_valid = 0; on in_valid & in_ready, load in_data into a 64-bit shift register, set out_len = 1, go to EMIT.
REQ-014 EMIT: out_valid = 1; out_byte[6:0] = shift[6:0]; rest = shift >>> 7 (arithmetic).
REQ-015 Termination: out_last = 1 iff (rest == 0 and shift[6] == 0) or (rest == all-ones and shift[6] == 1); out_byte[7] = ~out_last.
REQ-016 On out_valid & out_ready & ~out_last: shift <= rest, out_len <= out_len + 1, stay in EMIT.
REQ-017 On out_valid & out_ready & out_last: if in_valid, load the new value (out_len = 1, stay in EMIT); else go to IDLE.
REQ-018 in_ready SHALL be combinational: (state == IDLE) | (EMIT & out_ready & out_last), giving zero-bubble back-to-back throughput.
REQ-019 While out_valid & ~out_ready: out_byte, out_last and out_len SHALL hold stable; out_valid SHALL NOT drop.
REQ-020 Latency: first byte valid the cycle after the in_valid & in_ready handshake; one byte per cycle with out_ready held high.
REQ-021 Encoded length SHALL never exceed 10; the 10th byte always has out_last = 1 (bound reached at INT64_MIN and INT64_MAX).
REQ-022 in_data is sampled only on handshake; changes at other times SHALL have no effect.

Reset
REQ-023 rstn low SHALL immediately force state = IDLE, shift = 0, out_len = 0, out_valid = 0, out_last = 0, out_byte = 0x00, in_ready = 1.
REQ-024 Reset mid-value SHALL abandon the value; no further bytes of it SHALL be emitted after rstn deasserts.

Configuration
REQ-025 Macro PACK_I64_UNSIGNED_EN: when defined, add input port in_unsigned (1 bit), sampled with in_data; a value loaded with in_unsigned = 1 uses a logical shift and terminates iff rest == 0 (ULEB128, max 10 bytes).
REQ-026 Without PACK_I64_UNSIGNED_EN: in_unsigned SHALL NOT exist and all values are encoded signed.

Verification
REQ-027 in_data = 1, out_ready = 1 -> single byte 0x01, out_last = 1, out_len = 1.
REQ-028 in_data = -1 -> single byte 0x7F, out_last = 1, out_len = 1.
REQ-029 in_data = 0x00000000_C0000000 -> bytes 80 80 80 80 0C; out_last only on 0x0C, out_len = 5.
REQ-030 in_data = 0x80000000_00000000 -> nine 0x80 bytes then 0x7F, out_len = 10; in_data = 64 -> C0 00; out_ready low for 3 cycles during 0xC0 -> 0xC0 held stable, out_valid stays 1.
REQ-031 Back-to-back 1 then -1 with in_valid held -> 0x01, 0x7F on consecutive cycles, in_ready = 1 on the 0x01 cycle.
REQ-032 rstn pulsed low during the 3rd byte of 0xC0000000 -> out_valid = 0 immediately, IDLE after release, no remaining bytes; with PACK_I64_UNSIGNED_EN, in_unsigned = 1 and in_data = 64 -> single byte 0x40.

Source files
------------

// File: rtl/pack_i64_ser.sv
`default_nettype none
// ============================================================================
// Module   : pack_i64_ser
// Purpose  : Serialises a 64-bit two's-complement value into signed LEB128
//            bytes, one byte per cycle, with valid/ready on both sides.
//            Back-to-back values flow with no idle cycle between them.
// Ports    : clk        - sole clock, rising edge
//            rstn       - asynchronous active-low reset
//            in_data    - value to encode, sampled on in_valid & in_ready
//            in_unsigned- (PACK_I64_UNSIGNED_EN only) encode as ULEB128
//            in_valid   - in_data valid
//            in_ready   - block accepts a value this cycle
//            out_byte   - current LEB128 byte (bit7 = continuation)
//            out_valid  - out_byte valid
//            out_ready  - downstream accepts out_byte
//            out_last   - out_byte is the final byte of the value
//            out_len    - 1-based index of out_byte within the value
// Config   : define PACK_I64_UNSIGNED_EN to add in_unsigned (ULEB128 option)
// Revision : 1.0 - initial release
// ============================================================================
module pack_i64_ser (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] in_data,
`ifdef PACK_I64_UNSIGNED_EN
  input  logic        in_unsigned,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [3:0]  out_len
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state;
  logic [63:0] shift;
  logic [3:0]  len_q;
  logic [63:0] rest;
  logic        term;
  logic        emitting;
  logic        load;

`ifdef PACK_I64_UNSIGNED_EN
  logic        uns_q;
`endif

  // Remaining bits after this byte, and whether they are pure sign
  // extension of the payload just sent (then this byte ends the value).
  always_comb begin
    rest = $signed(shift) >>> 7;
    term = ((rest == 64'd0) && !shift[6]) ||
           ((rest == {64{1'b1}}) && shift[6]);
`ifdef PACK_I64_UNSIGNED_EN
    if (uns_q) begin
      rest = shift >> 7;
      term = (rest == 64'd0);
    end
`endif
  end

  // Outputs decode only from registered state, so they stay stable while
  // the downstream stalls.
  assign emitting  = (state == EMIT);
  assign out_valid = emitting;
  assign out_last  = emitting & term;
  assign out_byte  = emitting ? {~term, shift[6:0]} : 8'h00;
  assign out_len   = len_q;

  // A new value can be taken while the last byte of the previous one is
  // being accepted, which removes the bubble between values.
  assign in_ready  = ~emitting | (out_ready & term);
  assign load      = in_valid & in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      shift <= 64'd0;
      len_q <= 4'd0;
`ifdef PACK_I64_UNSIGNED_EN
      uns_q <= 1'b0;
`endif
    end else if (load) begin
      state <= EMIT;
      shift <= in_data;
      len_q <= 4'd1;
`ifdef PACK_I64_UNSIGNED_EN
      uns_q <= in_unsigned;
`endif
    end else if (emitting && out_ready) begin
      if (!term) begin
        shift <= rest;
        len_q <= len_q + 4'd1;
      end else begin
        state <= IDLE;
        len_q <= 4'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pack_i64_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_pack_i64_ser
// Purpose  : Self-checking bench for pack_i64_ser. Expected bytes come from
//            a range-based LEB128 model (smallest n whose 7n-bit signed range
//            holds the value) rather than from byte-by-byte shifting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pack_i64_ser;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] in_data = 64'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic [3:0]  out_len;
`ifdef PACK_I64_UNSIGNED_EN
  logic        in_unsigned = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  pack_i64_ser dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
`ifdef PACK_I64_UNSIGNED_EN
    .in_unsigned(in_unsigned),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Smallest n such that v lies in the signed range of 7n bits; 10 always fits.
  function automatic int enc_len(input logic signed [63:0] v);
    logic signed [63:0] lim;
    for (int n = 1; n < 10; n++) begin
      lim = 64'sd1 <<< (7 * n - 1);
      if (v >= -lim && v < lim) return n;
    end
    return 10;
  endfunction

  function automatic logic [7:0] enc_byte(input logic signed [63:0] v, input int i, input int n);
    logic signed [63:0] t;
    t = v >>> (7 * i);
    return {(i < n - 1) ? 1'b1 : 1'b0, t[6:0]};
  endfunction

  // Offer one value from idle, then follow its bytes with optional random
  // backpressure; outputs are sampled on the falling edge.
  task automatic send_value(input logic signed [63:0] v, input bit rand_stall);
    int n;
    int i;
    int cyc;
    n = enc_len(v);
    in_data  = v;
    in_valid = 1'b1;
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    i = 0;
    cyc = 0;
    while (i < n && cyc < 200) begin
      chk("out_valid", {63'd0, out_valid}, 64'd1);
      chk("out_byte", {56'd0, out_byte}, {56'd0, enc_byte(v, i, n)});
      chk("out_last", {63'd0, out_last}, (i == n - 1) ? 64'd1 : 64'd0);
      chk("out_len", {60'd0, out_len}, i + 1);
      out_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) i++;
      cyc++;
      in_data = {$urandom, $urandom};
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("bytes_done", i, n);
    chk("idle_after", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic signed [63:0] r;
    logic signed [63:0] v;

    // Reset state
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_len", {60'd0, out_len}, 64'd0);
    chk("rst_out_byte", {56'd0, out_byte}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Directed values
    send_value(64'sd1, 1'b0);
    send_value(-64'sd1, 1'b0);
    send_value(64'sh0000_0000_C000_0000, 1'b0);
    send_value(64'sh8000_0000_0000_0000, 1'b0);
    send_value(64'sh7FFF_FFFF_FFFF_FFFF, 1'b0);
    send_value(64'sd63, 1'b0);
    send_value(-64'sd64, 1'b0);
    send_value(-64'sd65, 1'b0);

    // 64 -> C0 00 with a 3-cycle stall on the first byte
    in_data  = 64'd64;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_byte", {56'd0, out_byte}, 64'hC0);
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_len", {60'd0, out_len}, 64'd1);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      in_data = {$urandom, $urandom};
      @(negedge clk);
    end
    chk("stall_byte_release", {56'd0, out_byte}, 64'hC0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_byte2", {56'd0, out_byte}, 64'h00);
    chk("stall_last2", {63'd0, out_last}, 64'd1);
    chk("stall_len2", {60'd0, out_len}, 64'd2);
    @(negedge clk);
    chk("stall_idle", {63'd0, out_valid}, 64'd0);

    // Back-to-back 1 then -1
    in_data  = 64'd1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_byte1", {56'd0, out_byte}, 64'h01);
    chk("b2b_ready1", {63'd0, in_ready}, 64'd1);
    chk("b2b_last1", {63'd0, out_last}, 64'd1);
    in_data = {64{1'b1}};
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_byte2", {56'd0, out_byte}, 64'h7F);
    chk("b2b_len2", {60'd0, out_len}, 64'd1);
    chk("b2b_valid2", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    chk("b2b_idle", {63'd0, out_valid}, 64'd0);

    // Reset during the 3rd byte of 0xC0000000
    in_data  = 64'h0000_0000_C000_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_byte3", {56'd0, out_byte}, 64'h80);
    chk("rst_mid_len3", {60'd0, out_len}, 64'd3);
    rstn = 1'b0;
    #1;
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_mid_len", {60'd0, out_len}, 64'd0);
    chk("rst_mid_byte", {56'd0, out_byte}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_abandon", {63'd0, out_valid}, 64'd0);
    end

`ifdef PACK_I64_UNSIGNED_EN
    in_data     = 64'd64;
    in_unsigned = 1'b1;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid    = 1'b0;
    in_unsigned = 1'b0;
    chk("uns_byte", {56'd0, out_byte}, 64'h40);
    chk("uns_last", {63'd0, out_last}, 64'd1);
    chk("uns_len", {60'd0, out_len}, 64'd1);
    @(negedge clk);
    chk("uns_idle", {63'd0, out_valid}, 64'd0);
`endif

    // Random values of varied magnitude with random backpressure
    for (int k = 0; k < 60; k++) begin
      r = {$urandom, $urandom};
      v = r >>> $urandom_range(0, 63);
      send_value(v, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
